// File: rtl/traffic_pkg.sv
// Shared light codes, fault codes, monitor state encoding and road status
// bundle for the traffic-light conflict monitor.
package traffic_pkg;

    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] GREEN   = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_ENCODING  = 3'd2;
    localparam logic [2:0] FC_TRANSITION = 3'd3;
    localparam logic [2:0] FC_SHORT_YEL = 3'd4;
    localparam logic [2:0] FC_SHORT_RED = 3'd5;
    localparam logic [2:0] FC_STUCK     = 3'd6;

    localparam logic [1:0] MON_ARM   = 2'd0;
    localparam logic [1:0] MON_RUN   = 2'd1;
    localparam logic [1:0] MON_FAULT = 2'd2;

    typedef struct packed {
        logic bad_trans;
        logic short_yel;
        logic enter_green;
        logic is_red;
    } road_status_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/road_tracker.sv
// Per-road history: previous sample, consecutive-yellow dwell counter and
// the transition checks that depend on them.
module road_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic [1:0]   light,
    output road_status_t status
);

    localparam logic [7:0] MIN_YEL8 = 8'(MIN_YELLOW);

    logic [1:0] prev;
    logic [7:0] yel_cnt;

    // yel_cnt counts consecutive YELLOW samples up to and including prev
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            prev    <= RED;
            yel_cnt <= 8'd0;
        end else begin
            prev    <= light;
            yel_cnt <= (light == YELLOW) ? sat_inc8(yel_cnt) : 8'd0;
        end
    end

    always_comb begin
        status.bad_trans   = ((prev == GREEN)  && (light == RED))    ||
                             ((prev == YELLOW) && (light == GREEN))  ||
                             ((prev == RED)    && (light == YELLOW));
        status.short_yel   = (prev == YELLOW) && (light == RED) && (yel_cnt < MIN_YEL8);
        status.enter_green = (light == GREEN) && (prev != GREEN);
        status.is_red      = (light == RED);
    end

endmodule

// File: rtl/conflict_monitor.sv
// Traffic-light conflict monitor: latches the first (lowest-code) fault and
// holds it until a safe acknowledge. Optional green-stuck check: CONFLICT_MONITOR_STUCK_EN.
module conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MIN_ALLRED = 2,
    parameter int MAX_GREEN  = 64
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       fault_ack,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       armed
);

    localparam logic [7:0] MIN_AR8 = 8'(MIN_ALLRED);

    logic [1:0]   state;
    logic [7:0]   allred_cnt;
    road_status_t hwy_st;
    road_status_t cntry_st;
    logic         run;
    logic         both_red;
    logic         conflict;
    logic         bad_enc;
    logic         stuck;
    logic         ack_ok;
    logic [2:0]   code_next;

    road_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_hwy (
        .clock   (clock),
        .clear_n (clear_n),
        .light   (hwy),
        .status  (hwy_st)
    );

    road_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_cntry (
        .clock   (clock),
        .clear_n (clear_n),
        .light   (cntry),
        .status  (cntry_st)
    );

    assign run      = (state == MON_RUN);
    assign both_red = hwy_st.is_red && cntry_st.is_red;
    assign conflict = (hwy != RED) && (cntry != RED);
    assign bad_enc  = (hwy == ILLEGAL) || (cntry == ILLEGAL);
    // both RED already rules out an illegal code on either road
    assign ack_ok   = fault_ack && both_red;
    assign armed    = run;

`ifdef CONFLICT_MONITOR_STUCK_EN
    localparam int GW = $clog2(MAX_GREEN + 1);
    localparam logic [GW-1:0] MAX_G = GW'(MAX_GREEN);

    // consecutive cntry GREEN samples up to and including the previous one
    logic [GW-1:0] green_cnt;

    always_ff @(posedge clock) begin
        if (!clear_n)
            green_cnt <= '0;
        else if (cntry == GREEN)
            green_cnt <= (green_cnt == '1) ? green_cnt : green_cnt + GW'(1);
        else
            green_cnt <= '0;
    end

    assign stuck = run && (cntry == GREEN) && (green_cnt >= MAX_G);
`else
    assign stuck = 1'b0;
`endif

    always_comb begin
        code_next = FC_NONE;
        if (conflict)
            code_next = FC_CONFLICT;
        else if (bad_enc)
            code_next = FC_ENCODING;
        else if (run && (hwy_st.bad_trans || cntry_st.bad_trans))
            code_next = FC_TRANSITION;
        else if (run && (hwy_st.short_yel || cntry_st.short_yel))
            code_next = FC_SHORT_YEL;
        else if (run && (hwy_st.enter_green || cntry_st.enter_green) && (allred_cnt < MIN_AR8))
            code_next = FC_SHORT_RED;
        else if (stuck)
            code_next = FC_STUCK;
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state      <= MON_ARM;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            allred_cnt <= MIN_AR8;
        end else begin
            allred_cnt <= both_red ? sat_inc8(allred_cnt) : 8'd0;
            case (state)
                MON_ARM, MON_RUN: begin
                    if (code_next != FC_NONE) begin
                        state      <= MON_FAULT;
                        fault      <= 1'b1;
                        fault_code <= code_next;
                    end else begin
                        state <= MON_RUN;
                    end
                end
                MON_FAULT: begin
                    if (ack_ok) begin
                        state      <= MON_ARM;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                    end
                end
                default: state <= MON_ARM;
            endcase
        end
    end

endmodule
